// File: rtl/fifo_rr_arbiter_if.sv
// Signal bundle between the round-robin pop arbiter, its source FIFOs and the downstream FIFO.
// The master modport is the arbiter; the slave modport is the FIFO side.
interface fifo_rr_arbiter_if #(
   parameter int N_PORTS    = 4,
   parameter int DATA_WIDTH = 6,
   parameter int IDX_W      = 2
);
   logic [N_PORTS-1:0]            fifo_empty;
   logic [N_PORTS-1:0]            fifo_error;
   logic [N_PORTS*DATA_WIDTH-1:0] fifo_data;
   logic                          pausa;
   logic [N_PORTS-1:0]            pop;
   logic                          push_out;
   logic [DATA_WIDTH-1:0]         data_out;
   logic [IDX_W-1:0]              grant_id;
   logic                          arb_error;
   logic                          busy;

   modport master (
      input  fifo_empty, fifo_error, fifo_data, pausa,
      output pop, push_out, data_out, grant_id, arb_error, busy
   );

   modport slave (
      output fifo_empty, fifo_error, fifo_data, pausa,
      input  pop, push_out, data_out, grant_id, arb_error, busy
   );
endinterface

// File: rtl/fifo_rr_arbiter.sv
// Round-robin pop arbiter draining N_PORTS source FIFOs into one downstream FIFO (pop -> push in 2 cycles).
// Optional macro ARB_PRIO_EN: port 0 gets strict priority; the remaining ports round-robin among themselves.
module fifo_rr_arbiter #(
   parameter int N_PORTS    = 4,
   parameter int DATA_WIDTH = 6,
   parameter int IDX_W      = 2
) (
   input  logic              clk,
   input  logic              reset,
   fifo_rr_arbiter_if.master bus
);

`ifdef ARB_PRIO_EN
   localparam bit PRIO_EN = 1'b1;
`else
   localparam bit PRIO_EN = 1'b0;
`endif

   typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_PAUSED, S_ERROR} state_t;

   state_t                r_state;
   logic [IDX_W-1:0]      r_ptr;
   logic                  r_s1_vld;
   logic [IDX_W-1:0]      r_s1_idx;
   logic                  r_push;
   logic [DATA_WIDTH-1:0] r_data;
   logic [IDX_W-1:0]      r_gid;
   logic                  r_err;

   logic                  w_any_ne;
   logic                  w_any_err;
   logic                  w_pop_en;
   logic                  w_ptr_upd;
   logic [IDX_W-1:0]      w_idx;
   logic [IDX_W-1:0]      w_cand;
   logic [DATA_WIDTH-1:0] w_word;

   assign w_any_ne  = ~&bus.fifo_empty;
   assign w_any_err = |bus.fifo_error;

   // Search runs farthest-first so the last hit (the nearest port after r_ptr) wins.
   // NOTE: every variable written here gets a default first, so no latch can be inferred.
   always_comb begin
      w_idx     = '0;
      w_cand    = '0;
      w_ptr_upd = 1'b0;
      for (int i = N_PORTS; i >= 1; i--) begin
         w_cand = IDX_W'((int'(r_ptr) + i) % N_PORTS);
         if (!bus.fifo_empty[w_cand] && !(PRIO_EN && (w_cand == '0))) begin
            w_idx     = w_cand;
            w_ptr_upd = 1'b1;
         end
      end
      if (PRIO_EN && !bus.fifo_empty[0]) begin
         w_idx     = '0;
         w_ptr_upd = 1'b0;
      end
   end

   always_comb begin
      w_word = '0;
      for (int i = 0; i < N_PORTS; i++) begin
         if (r_s1_idx == IDX_W'(i)) w_word = bus.fifo_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   // PAUSED and ERROR never pop; reset forces pop low combinationally.
   assign w_pop_en = !reset && ((r_state == S_IDLE) || (r_state == S_ACTIVE))
                     && !bus.pausa && w_any_ne;

   assign bus.pop = w_pop_en ? (N_PORTS'(1) << w_idx) : '0;

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_ptr    <= IDX_W'(N_PORTS - 1);
         r_s1_vld <= 1'b0;
         r_s1_idx <= '0;
         r_push   <= 1'b0;
         r_data   <= '0;
         r_gid    <= '0;
         r_err    <= 1'b0;
      end else begin
         r_s1_vld <= w_pop_en;
         if (w_pop_en) r_s1_idx <= w_idx;
         r_push <= r_s1_vld;
         if (r_s1_vld) begin
            r_data <= w_word;
            r_gid  <= r_s1_idx;
         end
         if (w_pop_en && w_ptr_upd) r_ptr <= w_idx;

         if (w_any_err) begin
            r_state <= S_ERROR;
            r_err   <= 1'b1;
         end else begin
            case (r_state)
               S_IDLE:   if (!bus.pausa && w_any_ne) r_state <= S_ACTIVE;
               S_ACTIVE: begin
                  if (bus.pausa)     r_state <= S_PAUSED;
                  else if (!w_any_ne) r_state <= S_IDLE;
               end
               S_PAUSED: if (!bus.pausa) r_state <= w_any_ne ? S_ACTIVE : S_IDLE;
               S_ERROR:  r_state <= S_ERROR;
            endcase
         end
      end
   end

   assign bus.push_out  = r_push;
   assign bus.data_out  = r_data;
   assign bus.grant_id  = r_gid;
   assign bus.arb_error = r_err;
   assign bus.busy      = r_s1_vld;

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Self-checking bench: source FIFOs modelled as arrays, arbiter checked against a cycle-level reference
// built from queues of expected pushes; directed scenarios followed by a randomized phase.
module tb_fifo_rr_arbiter;
   localparam int N     = 4;
   localparam int W     = 6;
   localparam int IW    = 2;
   localparam int DEPTH = 16;

   typedef struct {
      int         due;
      int         id;
      logic [W-1:0] word;
   } exp_t;

   typedef struct {
      int           id;
      logic [W-1:0] word;
   } got_t;

   logic clk;
   logic reset;

   fifo_rr_arbiter_if #(.N_PORTS(N), .DATA_WIDTH(W), .IDX_W(IW)) bus ();

   fifo_rr_arbiter #(.N_PORTS(N), .DATA_WIDTH(W), .IDX_W(IW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // source FIFO environment
   logic [W-1:0] src_mem  [N][DEPTH];
   int           src_head [N];
   int           src_tail [N];
   logic [W-1:0] src_dout [N];
   logic [N-1:0] refill_mask = '0;
   int           refill_lvl  = 2;
   bit           rand_mode   = 1'b0;

   // reference model
   int           m_ptr;
   bit           m_frozen, m_hold, m_engaged;
   logic [W-1:0] m_last_data;
   int           m_last_gid;
   bit           outs_valid = 1'b0;
   exp_t         exp_q[$];
   got_t         got_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic drive_src();
      for (int i = 0; i < N; i++) begin
         bus.fifo_empty[i]       = (src_tail[i] == src_head[i]);
         bus.fifo_data[i*W +: W] = src_dout[i];
      end
   endtask

   task automatic load(input int p, input logic [W-1:0] w);
      src_mem[p][src_tail[p] % DEPTH] = w;
      src_tail[p]++;
   endtask

   task automatic flush_src();
      for (int i = 0; i < N; i++) begin
         src_head[i] = 0;
         src_tail[i] = 0;
         src_dout[i] = '0;
      end
   endtask

   // First non-empty port after the pointer, modulo N (port 0 first when prioritised).
   function automatic int pick(input logic [N-1:0] ne);
`ifdef ARB_PRIO_EN
      if (ne[0]) return 0;
      for (int i = 1; i <= N; i++) begin
         int c = (m_ptr + i) % N;
         if (c != 0 && ne[c]) return c;
      end
`else
      for (int i = 1; i <= N; i++) begin
         int c = (m_ptr + i) % N;
         if (ne[c]) return c;
      end
`endif
      return -1;
   endfunction

   task automatic check_outputs();
      exp_t e;
      bit   e_push, e_busy;
      if (outs_valid) begin
         e_push = (exp_q.size() > 0) && (exp_q[0].due == cyc);
         if (e_push) begin
            e           = exp_q.pop_front();
            m_last_data = e.word;
            m_last_gid  = e.id;
         end
         e_busy = (exp_q.size() > 0) && (exp_q[$].due == cyc + 1);
         check("push_out",  bus.push_out,  e_push);
         check("data_out",  bus.data_out,  m_last_data);
         check("grant_id",  bus.grant_id,  m_last_gid);
         check("busy",      bus.busy,      e_busy);
         check("arb_error", bus.arb_error, m_frozen);
      end
      if (bus.push_out === 1'b1) got_q.push_back('{id: int'(bus.grant_id), word: bus.data_out});
   endtask

   task automatic tick();
      logic [N-1:0] e_pop, s_pop, ne;
      bit           s_reset, s_pausa, s_err;
      int           g;
      @(negedge clk);
      check_outputs();
      ne      = ~bus.fifo_empty;
      s_reset = reset;
      s_pausa = bus.pausa;
      s_err   = |bus.fifo_error;
      g       = -1;
      e_pop   = '0;
      if (!s_reset && !m_frozen && !m_hold && !s_pausa && ne != '0) begin
         g        = pick(ne);
         e_pop[g] = 1'b1;
      end
      check("pop", bus.pop, e_pop);
      s_pop = bus.pop;

      @(posedge clk);
      #1;
      cyc++;
      if (s_reset) begin
         exp_q.delete();
         m_ptr       = N - 1;
         m_frozen    = 1'b0;
         m_hold      = 1'b0;
         m_engaged   = 1'b0;
         m_last_data = '0;
         m_last_gid  = 0;
         outs_valid  = 1'b1;
      end else begin
         if (g >= 0) begin
            exp_q.push_back('{due: cyc + 1, id: g, word: src_mem[g][src_head[g] % DEPTH]});
`ifdef ARB_PRIO_EN
            if (g != 0) m_ptr = g;
`else
            m_ptr = g;
`endif
         end
         if (s_err) m_frozen = 1'b1;
         else if (!m_frozen) begin
            if (m_hold) begin
               if (!s_pausa) begin
                  m_hold    = 1'b0;
                  m_engaged = (ne != '0);
               end
            end else if (s_pausa) begin
               if (m_engaged) m_hold = 1'b1;
            end else begin
               m_engaged = (ne != '0);
            end
         end
      end

      for (int i = 0; i < N; i++) begin
         if (s_pop[i] && src_tail[i] != src_head[i]) begin
            src_dout[i] = src_mem[i][src_head[i] % DEPTH];
            src_head[i]++;
         end
         if (refill_mask[i] && (src_tail[i] - src_head[i]) < refill_lvl)
            if (!rand_mode || $urandom_range(0, 99) < 40) load(i, W'($urandom));
      end
      drive_src();
   endtask

   logic [W-1:0] t1_words [4] = '{6'h11, 6'h16, 6'h30, 6'h1C};
   logic [W-1:0] t2_words [3] = '{6'h1A, 6'h1B, 6'h1C};
`ifdef ARB_PRIO_EN
   int           t6_ids   [6] = '{0, 0, 0, 0, 2, 2};
`else
   int           t6_ids   [6] = '{0, 2, 0, 2, 0, 0};
`endif

   initial begin
      reset          = 1'b1;
      bus.pausa      = 1'b0;
      bus.fifo_error = '0;
      flush_src();
      drive_src();

      // 1: four ports, one word each
      for (int p = 0; p < 4; p++) load(p, t1_words[p]);
      drive_src();
      tick();
      tick();
      reset = 1'b0;
      check("rst_push_out",  bus.push_out,  1'b0);
      check("rst_data_out",  bus.data_out,  6'h00);
      check("rst_grant_id",  bus.grant_id,  2'd0);
      check("rst_arb_error", bus.arb_error, 1'b0);
      check("rst_busy",      bus.busy,      1'b0);
      got_q.delete();
      repeat (8) tick();
      check("t1_count", got_q.size(), 4);
      for (int i = 0; i < got_q.size() && i < 4; i++) begin
         check("t1_word", got_q[i].word, t1_words[i]);
         check("t1_gid",  got_q[i].id,   i);
      end

      // 2: single port back-to-back
      got_q.delete();
      for (int i = 0; i < 3; i++) load(2, t2_words[i]);
      drive_src();
      repeat (7) tick();
      check("t2_count", got_q.size(), 3);
      for (int i = 0; i < got_q.size() && i < 3; i++) check("t2_word", got_q[i].word, t2_words[i]);
      check("t2_idle_push", bus.push_out, 1'b0);

      // 3: ports 1 and 3 kept non-empty, pausa for 3 cycles
      refill_mask = 4'b1010;
      refill_lvl  = 2;
      repeat (5) tick();
      bus.pausa = 1'b1;
      repeat (3) tick();
      bus.pausa = 1'b0;
      repeat (8) tick();

      // 4: error while busy, then reset clears it
      refill_mask = 4'b1011;
      repeat (3) tick();
      bus.fifo_error[1] = 1'b1;
      tick();
      bus.fifo_error = '0;
      repeat (4) tick();
      check("t4_arb_error", bus.arb_error, 1'b1);
      check("t4_pop_frozen", bus.pop, 4'b0000);
      refill_mask = '0;
      reset = 1'b1;
      flush_src();
      drive_src();
      tick();
      reset = 1'b0;
      check("t4_err_cleared", bus.arb_error, 1'b0);

      // 5: reset the cycle after a pop discards the word
      load(0, 6'h25);
      drive_src();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("t5_push_out", bus.push_out, 1'b0);
      check("t5_data_out", bus.data_out, 6'h00);
      check("t5_grant_id", bus.grant_id, 2'd0);
      check("t5_busy",     bus.busy,     1'b0);
      repeat (3) tick();

      // 6: ports 0 and 2 non-empty, port 0 with four words
      reset = 1'b1;
      flush_src();
      for (int i = 1; i <= 4; i++) load(0, W'(i));
      load(2, 6'h2A);
      load(2, 6'h2B);
      drive_src();
      tick();
      reset = 1'b0;
      got_q.delete();
      repeat (10) tick();
      check("t6_count", got_q.size(), 6);
      for (int i = 0; i < got_q.size() && i < 6; i++) check("t6_gid", got_q[i].id, t6_ids[i]);

      // randomized traffic with backpressure, then a random error
      refill_mask = 4'hF;
      refill_lvl  = 6;
      rand_mode   = 1'b1;
      repeat (400) begin
         bus.pausa = ($urandom_range(0, 99) < 15);
         tick();
      end
      bus.pausa = 1'b0;
      bus.fifo_error[$urandom_range(0, N-1)] = 1'b1;
      tick();
      bus.fifo_error = '0;
      repeat (6) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
